// File: rtl/rvv_backend_dispatch_bypass_pipe_pkg.sv
// Shared types and helpers for the dispatch operand-bypass pipe.
package rvv_backend_dispatch_bypass_pipe_pkg;

    typedef enum logic [1:0] {
        BODY_ACTIVE   = 2'd0,
        BODY_INACTIVE = 2'd1,
        TAIL          = 2'd2
    } BYTE_TYPE_t;

    localparam int OPN_VS1 = 0;
    localparam int OPN_VS2 = 1;
    localparam int OPN_VD  = 2;
    localparam int OPN_V0  = 3;

    // Distance of ROB entry idx from the head; larger = younger. depth is a power of two.
    function automatic int rob_age(int idx, int head, int depth);
        return (idx - head) & (depth - 1);
    endfunction

endpackage

// File: rtl/rvv_backend_byp_age_sel.sv
// Picks the youngest eligible ROB entry (largest age relative to head) for one operand byte.
module rvv_backend_byp_age_sel
    import rvv_backend_dispatch_bypass_pipe_pkg::*;
#(
    parameter int ROB_DEPTH = 8
) (
    input  logic [ROB_DEPTH-1:0]         eligible,
    input  logic [$clog2(ROB_DEPTH)-1:0] head,
    output logic [ROB_DEPTH-1:0]         sel,
    output logic                         any
);
    int best_age;
    int best_idx;

    // Scan all entries, keep the eligible one with the greatest age, emit it one-hot.
    always_comb begin
        any      = 1'b0;
        best_age = 0;
        best_idx = 0;
        sel      = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (eligible[i] && (!any || rob_age(i, int'(head), ROB_DEPTH) > best_age)) begin
                best_age = rob_age(i, int'(head), ROB_DEPTH);
                best_idx = i;
                any      = 1'b1;
            end
        end
        for (int i = 0; i < ROB_DEPTH; i++) begin
            sel[i] = any && (best_idx == i);
        end
    end

endmodule

// File: rtl/rvv_backend_dispatch_bypass_pipe.sv
// Dispatch operand-bypass stage: S1 register, per-byte ROB/VRF merge, output FIFO.
module rvv_backend_dispatch_bypass_pipe
    import rvv_backend_dispatch_bypass_pipe_pkg::*;
#(
    parameter int         ROB_DEPTH = 8,
    parameter int         VLENB     = 16,
    parameter int         NUM_OPN   = 4,
    parameter int         OUT_DEPTH = 2,
    parameter logic [7:0] AGN_FILL  = 8'hFF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [NUM_OPN-1:0][ROB_DEPTH-1:0]    req_hit,
    input  logic [$clog2(ROB_DEPTH)-1:0]         req_rob_head,
    input  logic [ROB_DEPTH-1:0][VLENB-1:0][7:0] rob_wdata,
    input  logic [ROB_DEPTH-1:0][VLENB-1:0][1:0] rob_byte_type,
    input  logic [ROB_DEPTH-1:0]                 rob_inact_one,
    input  logic [ROB_DEPTH-1:0]                 rob_tail_one,
    input  logic [NUM_OPN-1:0][VLENB-1:0][7:0]   vrf_rdata,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_OPN-1:0][VLENB-1:0][7:0]   out_opnd,
    output logic [NUM_OPN-1:0][VLENB-1:0]        out_byp_mask
);
    localparam int IW = $clog2(ROB_DEPTH);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic [NUM_OPN-1:0][ROB_DEPTH-1:0] hit;
        logic [IW-1:0]                     head;
    } s1_req_t;

    typedef struct packed {
        logic [NUM_OPN-1:0][VLENB-1:0][7:0] opnd;
        logic [NUM_OPN-1:0][VLENB-1:0]      mask;
    } ent_t;

    logic          s1_v;
    s1_req_t       s1_req;
    logic          accept;
    logic          pop;
    ent_t          s1_ent;
    ent_t          head_ent;
    ent_t          hold_q;
    ent_t          fifo_mem [OUT_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready ignores a same-cycle pop, so whatever sits in S1 always has a FIFO slot.
    assign req_ready = !rst && !flush && (int'(count) + int'(s1_v) < OUT_DEPTH);
    assign accept    = req_valid && req_ready;

    // S1 capture: hit vectors and head of the accepted request, valid for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_req <= '0;
        end else begin
            s1_v <= accept;
            if (accept) s1_req <= '{hit: req_hit, head: req_rob_head};
        end
    end

    for (genvar o = 0; o < NUM_OPN; o++) begin : g_opn
        for (genvar j = 0; j < VLENB; j++) begin : g_byte
            logic [ROB_DEPTH-1:0] elig;
            logic [ROB_DEPTH-1:0] agn;
            logic [ROB_DEPTH-1:0] sel;
            logic                 any;
            logic [7:0]           rob_byte;

            // Per-entry eligibility: active bytes always, inactive/tail only when agnostic.
            always_comb begin
                elig = '0;
                agn  = '0;
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    agn[i]  = (rob_byte_type[i][j] != BODY_ACTIVE);
                    elig[i] = s1_req.hit[o][i] &&
                              ((rob_byte_type[i][j] == BODY_ACTIVE) ||
                               (rob_byte_type[i][j] == BODY_INACTIVE && rob_inact_one[i]) ||
                               (rob_byte_type[i][j] == TAIL && rob_tail_one[i]));
                end
            end

            rvv_backend_byp_age_sel #(.ROB_DEPTH(ROB_DEPTH)) u_sel (
                .eligible (elig),
                .head     (s1_req.head),
                .sel      (sel),
                .any      (any)
            );

            // One-hot AND-OR mux of the winning entry's byte (fill value if agnostic).
            always_comb begin
                rob_byte = '0;
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (sel[i]) rob_byte = rob_byte | (agn[i] ? AGN_FILL : rob_wdata[i][j]);
                end
            end

            assign s1_ent.opnd[o][j] = any ? rob_byte : vrf_rdata[o][j];
            assign s1_ent.mask[o][j] = any;
        end
    end

    assign out_valid    = (count != '0);
    assign pop          = out_valid && out_ready;
    assign head_ent     = out_valid ? fifo_mem[rd_ptr] : hold_q;
    assign out_opnd     = head_ent.opnd;
    assign out_byp_mask = head_ent.mask;

    // Output FIFO; hold_q remembers the last presented entry so outputs stay put when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= '0;
            for (int k = 0; k < OUT_DEPTH; k++) fifo_mem[k] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            hold_q <= head_ent;
        end else begin
            if (s1_v) begin
                fifo_mem[wr_ptr] <= s1_ent;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count  <= count + CW'(s1_v) - CW'(pop);
            hold_q <= head_ent;
        end
    end

endmodule

// File: tb/tb_rvv_backend_dispatch_bypass_pipe.sv
// Bench for the dispatch operand-bypass pipe: directed table, corner sequences, random vs model.
module tb_rvv_backend_dispatch_bypass_pipe;
    import rvv_backend_dispatch_bypass_pipe_pkg::*;

    localparam int RD  = 8;
    localparam int VB  = 16;
    localparam int NO  = 4;
    localparam int OD  = 2;
    localparam int RD2 = 16;
    localparam int VB2 = 32;

    typedef logic [NO-1:0][VB-1:0][7:0] opnd_t;
    typedef logic [NO-1:0][VB-1:0]      mask_t;
    typedef logic [NO-1:0][RD-1:0]      hit_t;
    typedef struct packed { opnd_t opnd; mask_t mask; } ent_t;

    typedef struct {
        int         op;
        logic [7:0] hit;
        logic [2:0] head;
        logic [1:0] btype;
        logic [7:0] inact1;
        logic [7:0] tail1;
        logic [7:0] exp_byte;
        logic       exp_mask;
    } vec_t;

    logic clk = 1'b0;
    logic rst, flush, req_valid, req_ready, out_valid, out_ready;
    hit_t                         req_hit;
    logic [2:0]                   req_rob_head;
    logic [RD-1:0][VB-1:0][7:0]   rob_wdata;
    logic [RD-1:0][VB-1:0][1:0]   rob_byte_type;
    logic [RD-1:0]                rob_inact_one, rob_tail_one;
    opnd_t                        vrf_rdata, out_opnd;
    mask_t                        out_byp_mask;

    logic                         req_valid_b, req_ready_b, out_valid_b, out_ready_b;
    logic [NO-1:0][RD2-1:0]       req_hit_b;
    logic [3:0]                   head_b;
    logic [RD2-1:0][VB2-1:0][7:0] rob_wdata_b;
    logic [RD2-1:0][VB2-1:0][1:0] rob_type_b;
    logic [RD2-1:0]               inact_b, tail_b;
    logic [NO-1:0][VB2-1:0][7:0]  vrf_b, out_opnd_b;
    logic [NO-1:0][VB2-1:0]       mask_b;

    rvv_backend_dispatch_bypass_pipe #(.ROB_DEPTH(RD), .VLENB(VB), .NUM_OPN(NO), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_hit(req_hit), .req_rob_head(req_rob_head), .rob_wdata(rob_wdata),
        .rob_byte_type(rob_byte_type), .rob_inact_one(rob_inact_one), .rob_tail_one(rob_tail_one),
        .vrf_rdata(vrf_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_opnd(out_opnd), .out_byp_mask(out_byp_mask)
    );

    rvv_backend_dispatch_bypass_pipe #(.ROB_DEPTH(RD2), .VLENB(VB2), .NUM_OPN(NO), .OUT_DEPTH(OD)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_hit(req_hit_b), .req_rob_head(head_b), .rob_wdata(rob_wdata_b),
        .rob_byte_type(rob_type_b), .rob_inact_one(inact_b), .rob_tail_one(tail_b),
        .vrf_rdata(vrf_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_opnd(out_opnd_b), .out_byp_mask(mask_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic opnd_t fill(input logic [7:0] b);
        opnd_t r;
        for (int o = 0; o < NO; o++)
            for (int j = 0; j < VB; j++) r[o][j] = b;
        return r;
    endfunction

    // Reference: walk ages from youngest to oldest, first eligible entry supplies the byte.
    function automatic ent_t model_merge(input hit_t hit, input logic [2:0] head);
        ent_t r;
        for (int o = 0; o < NO; o++) begin
            for (int j = 0; j < VB; j++) begin
                r.opnd[o][j] = vrf_rdata[o][j];
                r.mask[o][j] = 1'b0;
                for (int a = RD - 1; a >= 0; a--) begin
                    int e;
                    logic [1:0] t;
                    logic ok;
                    e  = (int'(head) + a) % RD;
                    t  = rob_byte_type[e][j];
                    ok = hit[o][e] && (t == 2'd0 || (t == 2'd1 && rob_inact_one[e]) ||
                                       (t == 2'd2 && rob_tail_one[e]));
                    if (ok) begin
                        r.opnd[o][j] = (t == 2'd0) ? rob_wdata[e][j] : 8'hFF;
                        r.mask[o][j] = 1'b1;
                        break;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic rob_default();
        for (int i = 0; i < RD; i++)
            for (int j = 0; j < VB; j++) begin
                rob_wdata[i][j]     = {1'b1, 3'(i), 4'(j)};
                rob_byte_type[i][j] = 2'd0;
            end
        for (int o = 0; o < NO; o++)
            for (int j = 0; j < VB; j++) vrf_rdata[o][j] = {4'(o + 1), 4'(o + 1)};
        rob_inact_one = '0;
        rob_tail_one  = '0;
    endtask

    vec_t tbl[10];
    ent_t q[$];
    ent_t shown, last_shown;
    hit_t s1_hit;
    logic [2:0] s1_head;
    logic s1_pend, exp_ready;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{OPN_VS1, 8'h00, 3'd0, 2'd0, 8'h00, 8'h00, 8'h11, 1'b0};
        tbl[1] = '{OPN_VS2, 8'h24, 3'd0, 2'd0, 8'h00, 8'h00, 8'hD0, 1'b1};
        tbl[2] = '{OPN_VS2, 8'h24, 3'd4, 2'd0, 8'h00, 8'h00, 8'hA0, 1'b1};
        tbl[3] = '{OPN_VD,  8'h08, 3'd0, 2'd2, 8'h00, 8'h08, 8'hFF, 1'b1};
        tbl[4] = '{OPN_VD,  8'h08, 3'd0, 2'd2, 8'h00, 8'h00, 8'h33, 1'b0};
        tbl[5] = '{OPN_V0,  8'h42, 3'd6, 2'd1, 8'h02, 8'h00, 8'hFF, 1'b1};
        tbl[6] = '{OPN_VS2, 8'h24, 3'd0, 2'd2, 8'h00, 8'h04, 8'hFF, 1'b1};
        tbl[7] = '{OPN_VS1, 8'hC0, 3'd7, 2'd0, 8'h00, 8'h00, 8'hE0, 1'b1};
        tbl[8] = '{OPN_VS2, 8'hFF, 3'd3, 2'd0, 8'h00, 8'h00, 8'hA0, 1'b1};
        tbl[9] = '{OPN_VS2, 8'h10, 3'd0, 2'd1, 8'h00, 8'h00, 8'h22, 1'b0};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; out_ready = 1'b0;
        req_hit = '0; req_rob_head = '0;
        rob_default();
        req_valid_b = 1'b0; out_ready_b = 1'b1; req_hit_b = '0; head_b = '0;
        inact_b = '0; tail_b = '0;
        for (int i = 0; i < RD2; i++)
            for (int j = 0; j < VB2; j++) begin
                rob_wdata_b[i][j] = 8'(64 + i);
                rob_type_b[i][j]  = 2'd0;
            end
        for (int o = 0; o < NO; o++)
            for (int j = 0; j < VB2; j++) vrf_b[o][j] = 8'h11;

        // reset state
        @(negedge clk); #1;
        chk1("rst_ready_low", req_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_opnd", out_opnd, '0);
        chk("rst_byp_mask", 512'(out_byp_mask), '0);
        chk1("rst_ready_high", req_ready, 1'b1);

        // directed byte-selection table
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            rob_default();
            for (int i = 0; i < RD; i++) rob_byte_type[i][0] = tbl[v].btype;
            rob_inact_one = tbl[v].inact1;
            rob_tail_one  = tbl[v].tail1;
            req_hit = '0;
            req_hit[tbl[v].op] = tbl[v].hit;
            req_rob_head = tbl[v].head;
            req_valid = 1'b1; out_ready = 1'b0; #1;
            chk1($sformatf("tbl%0d_ready", v), req_ready, 1'b1);
            @(negedge clk);
            req_valid = 1'b0; #1;
            chk1($sformatf("tbl%0d_s1_not_valid", v), out_valid, 1'b0);
            @(negedge clk); #1;
            chk1($sformatf("tbl%0d_valid", v), out_valid, 1'b1);
            chk($sformatf("tbl%0d_byte", v), 512'(out_opnd[tbl[v].op][0]), 512'(tbl[v].exp_byte));
            chk1($sformatf("tbl%0d_mask", v), out_byp_mask[tbl[v].op][0], tbl[v].exp_mask);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end

        // back-pressure: three back-to-back requests with a stalled consumer
        rob_default(); req_hit = '0;
        @(negedge clk);
        req_valid = 1'b1; #1;
        chk1("bp_ready_a", req_ready, 1'b1);
        @(negedge clk);
        vrf_rdata = fill(8'hA1); #1;
        chk1("bp_ready_b", req_ready, 1'b1);
        @(negedge clk);
        vrf_rdata = fill(8'hB2); #1;
        chk1("bp_ready_full_s1", req_ready, 1'b0);
        chk1("bp_valid_a", out_valid, 1'b1);
        @(negedge clk);
        out_ready = 1'b1; #1;
        chk1("bp_ready_conservative", req_ready, 1'b0);
        chk("bp_head_a", out_opnd, fill(8'hA1));
        @(negedge clk); #1;
        chk1("bp_ready_c", req_ready, 1'b1);
        chk("bp_head_b", out_opnd, fill(8'hB2));
        @(negedge clk);
        req_valid = 1'b0; out_ready = 1'b0; vrf_rdata = fill(8'hC3); #1;
        chk1("bp_empty_during_c_s1", out_valid, 1'b0);
        @(negedge clk); #1;
        chk1("bp_valid_c", out_valid, 1'b1);
        chk("bp_head_c", out_opnd, fill(8'hC3));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; #1;
        chk1("bp_drained", out_valid, 1'b0);
        chk("bp_hold_when_empty", out_opnd, fill(8'hC3));

        // flush with S1 and FIFO both occupied
        @(negedge clk);
        vrf_rdata = fill(8'h5A); req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1; #1;
        chk1("fl_ready_in_flush", req_ready, 1'b0);
        chk1("fl_valid_before", out_valid, 1'b1);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; out_ready = 1'b1; #1;
        chk1("fl_valid_after", out_valid, 1'b0);
        chk1("fl_ready_after", req_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk1($sformatf("fl_no_stale_%0d", k), out_valid, 1'b0);
        end
        out_ready = 1'b0;

        // reset while holding data clears the presented operands
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_mid_opnd", out_opnd, '0);

        // wide build: age wraps around the head
        @(negedge clk);
        req_hit_b = '0; req_hit_b[0] = 16'h8002; head_b = 4'd14; req_valid_b = 1'b1; #1;
        chk1("b_ready", req_ready_b, 1'b1);
        @(negedge clk);
        req_valid_b = 1'b0;
        @(negedge clk); #1;
        chk1("b_valid", out_valid_b, 1'b1);
        chk("b_wrap_opnd", 512'(out_opnd_b[0]), 512'({VB2{8'h41}}));
        chk("b_wrap_mask", 512'(mask_b[0]), 512'({VB2{1'b1}}));
        chk("b_nohit_mask", 512'(mask_b[1]), '0);
        head_b = 4'd0; req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_b = 1'b0;
        @(negedge clk); #1;
        chk("b_head0_opnd", 512'(out_opnd_b[0]), 512'({VB2{8'h4F}}));

        // randomized traffic against the reference model
        q.delete(); s1_pend = 1'b0; last_shown = '0; s1_hit = '0; s1_head = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < RD; i++)
                for (int j = 0; j < VB; j++) begin
                    rob_wdata[i][j]     = 8'($urandom);
                    rob_byte_type[i][j] = 2'($urandom_range(0, 2));
                end
            for (int o = 0; o < NO; o++) begin
                req_hit[o] = 8'($urandom & $urandom);
                for (int j = 0; j < VB; j++) vrf_rdata[o][j] = 8'($urandom);
            end
            rob_inact_one = 8'($urandom);
            rob_tail_one  = 8'($urandom);
            req_rob_head  = 3'($urandom);
            req_valid     = ($urandom_range(0, 9) < 7);
            out_ready     = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 39) == 0);
            #1;
            exp_ready = !flush && (q.size() + int'(s1_pend) < OD);
            chk1("rand_ready", req_ready, exp_ready);
            chk1("rand_valid", out_valid, q.size() != 0);
            shown = (q.size() != 0) ? q[0] : last_shown;
            chk("rand_opnd", out_opnd, shown.opnd);
            chk("rand_mask", 512'(out_byp_mask), 512'(shown.mask));
            last_shown = shown;
            if (flush) begin
                q.delete();
                s1_pend = 1'b0;
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (s1_pend) q.push_back(model_merge(s1_hit, s1_head));
                s1_pend = req_valid && exp_ready;
                s1_hit  = req_hit;
                s1_head = req_rob_head;
            end
        end
        flush = 1'b0; req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
